lsu_unit: RTL and testbench

//  Multi-cycle load/store unit sitting between EXU and the memory bus; feeds load data to the WBU busW mux (MemtoReg=2'b01).

---
 rtl/lsu_unit_pkg.sv | 44 ++++
 rtl/lsu_unit_if.sv | 56 +++++
 rtl/lsu_unit_load_ext.sv | 30 +++
 rtl/lsu_unit.sv | 157 +++++++++++++++
 tb/tb_lsu_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_unit_pkg.sv
// -----------------------------------------------------------------------------
// lsu_unit_pkg
//   Shared encodings for the load/store unit: memory-op codes, the LSU FSM
//   state type, WBU MemtoReg select codes, and lane helpers used by the
//   store path.
// -----------------------------------------------------------------------------
package lsu_unit_pkg;

    // memop encodings (bit 2 = unsigned load)
    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    // WBU busW mux selects
    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } lsu_state_e;

    // Byte lane of the access: halfwords only look at addr[1], words at none.
    function automatic logic [1:0] lane_shift(input logic [2:0] memop, input logic [1:0] addr_lo);
        case (memop)
            MOP_B, MOP_BU: return addr_lo;
            MOP_H, MOP_HU: return {addr_lo[1], 1'b0};
            default:       return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [2:0] memop, input logic [1:0] addr_lo);
        case (memop)
            MOP_B, MOP_BU: return 4'b0001 << addr_lo;
            MOP_H, MOP_HU: return 4'b0011 << {addr_lo[1], 1'b0};
            default:       return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// -----------------------------------------------------------------------------
// lsu_unit_if
//   Bundles the three LSU handshakes: EXU request (in_*), WBU result (out_*)
//   and memory bus request/response (mem_*).
//   slave  : LSU view.
//   master : environment view (EXU + WBU + memory).
// -----------------------------------------------------------------------------
interface lsu_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [2:0]        in_memop;
    logic              in_wen;
    logic              in_ren;
    logic [31:0]       in_wdata;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rdata;
    logic              out_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [31:0]       mem_req_wdata;
    logic [3:0]        mem_req_wstrb;
    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [31:0]       mem_rsp_rdata;
    logic              mem_rsp_err;

    modport slave (
        input  in_valid, in_addr, in_memop, in_wen, in_ren, in_wdata,
        output in_ready,
        output out_valid, out_rdata, out_err,
        input  out_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
        output mem_rsp_ready
    );

    modport master (
        output in_valid, in_addr, in_memop, in_wen, in_ren, in_wdata,
        input  in_ready,
        input  out_valid, out_rdata, out_err,
        output out_ready,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/lsu_unit_load_ext.sv
// -----------------------------------------------------------------------------
// lsu_load_ext
//   Combinational load aligner: selects the addressed byte/halfword from the
//   full bus word and sign- or zero-extends it according to memop.
//   i_word    : 32-bit word returned by the bus
//   i_addr_lo : byte address bits [1:0]
//   i_memop   : access size/signedness
//   o_data    : extended 32-bit load result
// -----------------------------------------------------------------------------
module lsu_load_ext
    import lsu_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_memop,
    output logic [31:0] o_data
);
    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_word >> {lane_shift(i_memop, i_addr_lo), 3'b000};
        case (i_memop)
            MOP_B:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MOP_BU:  o_data = {24'h000000, w_shifted[7:0]};
            MOP_H:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MOP_HU:  o_data = {16'h0000, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end
endmodule

// File: rtl/lsu_unit.sv
// -----------------------------------------------------------------------------
// lsu_unit
//   Multi-cycle load/store unit between EXU and a valid/ready memory bus.
//   One transaction in flight: IDLE -> REQ -> RESP -> DONE -> IDLE.
//   Store data is shifted onto byte lanes with matching write strobes; load
//   data is aligned and extended by lsu_load_ext. Result goes to the WBU.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : lsu_unit_if.slave (in_*, out_*, mem_* handshakes)
// Parameters
//   ADDR_W   : address width
//   TIMEOUT  : cycles allowed in REQ+RESP before aborting with error (0 = off)
// Build option
//   LSU_MISALIGN_CHECK_EN : misaligned h/w accesses skip the bus and complete
//                           with out_err=1.
// -----------------------------------------------------------------------------
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,
    lsu_unit_if.slave bus
);
    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_memop;
    logic              r_wen;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       r_cnt;
    logic [31:0]       w_cnt_inc;
    logic              w_accept;
    logic              w_timeout;
    logic              w_misalign;
    logic              w_set_result;
    logic [31:0]       w_result_rdata;
    logic              w_result_err;
    logic [31:0]       w_ld_data;

    lsu_load_ext u_load_ext (
        .i_word    (bus.mem_rsp_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_memop   (r_memop),
        .o_data    (w_ld_data)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = ((bus.in_memop == MOP_H || bus.in_memop == MOP_HU) && bus.in_addr[0])
                     || (bus.in_memop == MOP_W && bus.in_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept  = bus.in_valid && (r_state == S_IDLE);
    assign w_cnt_inc = r_cnt + 32'd1;
    // Counter holds cycles already spent in REQ/RESP; this cycle is the last allowed.
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc >= TIMEOUT);

    // Request fields come only from latched state so they stay stable while stalled.
    assign bus.mem_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus.mem_req_wen   = r_wen;
    assign bus.mem_req_wdata = r_wdata << {lane_shift(r_memop, r_addr[1:0]), 3'b000};
    assign bus.mem_req_wstrb = r_wen ? lane_strb(r_memop, r_addr[1:0]) : 4'b0000;
    assign bus.out_rdata     = r_rdata;
    assign bus.out_err       = r_err;

    always_comb begin
        w_state_nxt       = r_state;
        w_set_result      = 1'b0;
        w_result_rdata    = '0;
        w_result_err      = 1'b0;
        bus.in_ready      = 1'b0;
        bus.out_valid     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_rsp_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (!bus.in_wen && !bus.in_ren) begin
                        w_state_nxt  = S_DONE;
                        w_set_result = 1'b1;
                    end else if (w_misalign) begin
                        w_state_nxt  = S_DONE;
                        w_set_result = 1'b1;
                        w_result_err = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_state_nxt  = S_DONE;
                    w_set_result = 1'b1;
                    w_result_err = 1'b1;
                end
            end
            S_RESP: begin
                bus.mem_rsp_ready = 1'b1;
                if (bus.mem_rsp_valid) begin
                    w_state_nxt    = S_DONE;
                    w_set_result   = 1'b1;
                    w_result_err   = bus.mem_rsp_err;
                    w_result_rdata = (r_wen || bus.mem_rsp_err) ? '0 : w_ld_data;
                end else if (w_timeout) begin
                    w_state_nxt  = S_DONE;
                    w_set_result = 1'b1;
                    w_result_err = 1'b1;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_memop <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= bus.in_addr;
                r_memop <= bus.in_memop;
                r_wen   <= bus.in_wen;
                r_wdata <= bus.in_wdata;
                r_cnt   <= '0;
            end else if (r_state == S_REQ || r_state == S_RESP) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_set_result) begin
                r_rdata <= w_result_rdata;
                r_err   <= w_result_err;
            end
        end
    end
endmodule

// File: tb/tb_lsu_unit.sv
module tb_lsu_unit;
    import lsu_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_unit_if #(.ADDR_W(32)) bus ();
    lsu_unit_if #(.ADDR_W(32)) tbus ();

    lsu_unit #(.ADDR_W(32), .TIMEOUT(255)) dut    (.clk(clk), .rst(rst), .bus(bus));
    lsu_unit #(.ADDR_W(32), .TIMEOUT(8))   dut_to (.clk(clk), .rst(rst), .bus(tbus));

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] ops [5] = '{MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU};

    // ---------------- reference model ----------------
    function automatic int m_lane(input logic [31:0] addr, input logic [2:0] op);
        if (op == MOP_B || op == MOP_BU) return int'(addr[1:0]);
        if (op == MOP_H || op == MOP_HU) return addr[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic int m_size(input logic [2:0] op);
        if (op == MOP_B || op == MOP_BU) return 1;
        if (op == MOP_H || op == MOP_HU) return 2;
        return 4;
    endfunction

    function automatic logic m_misalign(input logic [31:0] addr, input logic [2:0] op);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((op == MOP_H || op == MOP_HU) && addr[0]) return 1'b1;
        if (op == MOP_W && addr[1:0] != 2'b00) return 1'b1;
`endif
        return addr[31] & 1'b0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [31:0] addr, input logic [2:0] op);
        logic [3:0] s;
        int l, n;
        s = 4'b0000;
        l = m_lane(addr, op);
        n = m_size(op);
        for (int i = 0; i < 4; i++) if (i >= l && i < l + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr, input logic [2:0] op);
        logic [7:0]  by [4];
        logic [15:0] hw;
        int l;
        for (int i = 0; i < 4; i++) by[i] = word[8*i +: 8];
        l = m_lane(addr, op);
        case (op)
            MOP_B:  return {{24{by[l][7]}}, by[l]};
            MOP_BU: return {24'h000000, by[l]};
            MOP_H:  begin hw = {by[l+1], by[l]}; return {{16{hw[15]}}, hw}; end
            MOP_HU: begin hw = {by[l+1], by[l]}; return {16'h0000, hw}; end
            default: return word;
        endcase
    endfunction

    // ---------------- transaction driver ----------------
    task automatic run_txn(input logic [31:0] addr, input logic [2:0] op, input logic wen, input logic ren,
                           input logic [31:0] wdata, input logic [31:0] word, input logic rerr,
                           input int req_stall, input int rsp_delay, input int out_stall,
                           input logic [31:0] exp_in, input logic use_exp);
        logic        on_bus, exp_err;
        logic [31:0] exp_rdata, exp_wdata;
        logic [3:0]  exp_strb;
        on_bus    = (wen || ren) && !m_misalign(addr, op);
        exp_wdata = wdata << (8 * m_lane(addr, op));
        exp_strb  = wen ? m_strb(addr, op) : 4'b0000;
        if (!(wen || ren))            begin exp_rdata = 32'h0; exp_err = 1'b0; end
        else if (m_misalign(addr, op)) begin exp_rdata = 32'h0; exp_err = 1'b1; end
        else if (wen)                 begin exp_rdata = 32'h0; exp_err = rerr; end
        else begin exp_rdata = rerr ? 32'h0 : m_load(word, addr, op); exp_err = rerr; end
        if (use_exp) exp_rdata = exp_in;

        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL in_ready_idle: got %b expected 1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_addr = addr; bus.in_memop = op;
        bus.in_wen = wen; bus.in_ren = ren; bus.in_wdata = wdata;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_addr = $urandom; bus.in_wdata = $urandom;
        bus.in_memop = 3'($urandom_range(0, 7)); bus.in_wen = 1'($urandom_range(0, 1)); bus.in_ren = 1'($urandom_range(0, 1));
        if (on_bus) begin
            for (int k = 0; k <= req_stall; k++) begin
                n_vec++; if (bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL req_valid: got %b expected 1", bus.mem_req_valid); end
                n_vec++; if (bus.mem_req_addr !== {addr[31:2], 2'b00}) begin n_err++; $display("FAIL req_addr: got %h expected %h", bus.mem_req_addr, {addr[31:2], 2'b00}); end
                n_vec++; if (bus.mem_req_wen !== wen) begin n_err++; $display("FAIL req_wen: got %b expected %b", bus.mem_req_wen, wen); end
                n_vec++; if (bus.mem_req_wstrb !== exp_strb) begin n_err++; $display("FAIL req_wstrb: got %b expected %b", bus.mem_req_wstrb, exp_strb); end
                if (wen) begin
                    n_vec++; if (bus.mem_req_wdata !== exp_wdata) begin n_err++; $display("FAIL req_wdata: got %h expected %h", bus.mem_req_wdata, exp_wdata); end
                end
                n_vec++; if (bus.mem_rsp_ready !== 1'b0) begin n_err++; $display("FAIL rsp_ready_in_req: got %b expected 0", bus.mem_rsp_ready); end
                bus.mem_req_ready = (k == req_stall);
                bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = $urandom; // must be ignored in REQ
                @(posedge clk); #1;
                bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
            end
            for (int k = 0; k <= rsp_delay; k++) begin
                n_vec++; if (bus.mem_rsp_ready !== 1'b1) begin n_err++; $display("FAIL rsp_ready: got %b expected 1", bus.mem_rsp_ready); end
                n_vec++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL req_valid_in_resp: got %b expected 0", bus.mem_req_valid); end
                n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL out_valid_early: got %b expected 0", bus.out_valid); end
                bus.mem_rsp_valid = (k == rsp_delay);
                bus.mem_rsp_rdata = (k == rsp_delay) ? word : $urandom;
                bus.mem_rsp_err   = (k == rsp_delay) ? rerr : 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                bus.mem_rsp_valid = 1'b0; bus.mem_rsp_err = 1'b0; bus.mem_rsp_rdata = $urandom;
            end
        end else begin
            n_vec++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL req_valid_skip: got %b expected 0", bus.mem_req_valid); end
        end
        for (int k = 0; k <= out_stall; k++) begin
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL out_valid: got %b expected 1", bus.out_valid); end
            n_vec++; if (bus.out_rdata !== exp_rdata) begin n_err++; $display("FAIL out_rdata: got %h expected %h (addr %h op %b)", bus.out_rdata, exp_rdata, addr, op); end
            n_vec++; if (bus.out_err !== exp_err) begin n_err++; $display("FAIL out_err: got %b expected %b", bus.out_err, exp_err); end
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL in_ready_done: got %b expected 0", bus.in_ready); end
            bus.out_ready = (k == out_stall);
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL out_valid_after: got %b expected 0", bus.out_valid); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_vec++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b expected 0", bus.mem_req_valid); end
        n_vec++; if (bus.mem_rsp_ready !== 1'b0) begin n_err++; $display("FAIL rst_rsp_ready: got %b expected 0", bus.mem_rsp_ready); end
        n_vec++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL rst_out_err: got %b expected 0", bus.out_err); end
        n_vec++; if (bus.out_rdata !== 32'h0) begin n_err++; $display("FAIL rst_out_rdata: got %h expected 0", bus.out_rdata); end
        n_vec++; if (tbus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_to_in_ready: got %b expected 1", tbus.in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_txn(32'h8000_0003, MOP_B,  1'b0, 1'b1, 32'h0, 32'h80FF_1234, 1'b0, 0, 0, 0, 32'hFFFF_FF80, 1'b1);
        run_txn(32'h8000_0002, MOP_HU, 1'b0, 1'b1, 32'h0, 32'hBEEF_0000, 1'b0, 0, 0, 0, 32'h0000_BEEF, 1'b1);
        run_txn(32'h8000_0002, MOP_H,  1'b0, 1'b1, 32'h0, 32'hBEEF_0000, 1'b0, 0, 0, 0, 32'hFFFF_BEEF, 1'b1);
        run_txn(32'h8000_0001, MOP_B,  1'b1, 1'b0, 32'h0000_00AB, 32'h0, 1'b0, 0, 0, 0, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
        run_txn(32'h8000_0002, MOP_W,  1'b0, 1'b1, 32'h0, 32'h1122_3344, 1'b0, 0, 0, 3, 32'h0, 1'b1);
`else
        run_txn(32'h8000_0002, MOP_W,  1'b0, 1'b1, 32'h0, 32'h1122_3344, 1'b0, 0, 0, 3, 32'h1122_3344, 1'b1);
`endif
        // neither ren nor wen, then a bus error on a load
        run_txn(32'h8000_0010, MOP_W,  1'b0, 1'b0, 32'h5555_5555, 32'h0, 1'b0, 0, 0, 1, 32'h0, 1'b1);
        run_txn(32'h8000_0014, MOP_W,  1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b1, 0, 1, 0, 32'h0, 1'b1);
    endtask

    task automatic test_stall();
        run_txn(32'h8000_0008, MOP_W, 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 1'b0, 5, 3, 3, 32'hCAFE_F00D, 1'b1);
        run_txn(32'h8000_0006, MOP_H, 1'b1, 1'b1, 32'h0000_1234, 32'h0, 1'b0, 5, 3, 0, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic       wen, ren;
        int         kind;
        for (int i = 0; i < 60; i++) begin
            op   = ops[$urandom_range(0, 4)];
            kind = int'($urandom_range(0, 7));
            wen  = (kind < 3);
            ren  = (kind == 0) || (kind >= 3 && kind < 7);
            run_txn(32'h8000_0000 | ($urandom & 32'h0000_0FFF), op, wen, ren, $urandom, $urandom,
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 1)), 32'h0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.in_addr = 32'h8000_0004; bus.in_memop = MOP_W;
        bus.in_wen = 1'b1; bus.in_ren = 1'b0; bus.in_wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_vec++; if (bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL mid_req_valid: got %b expected 1", bus.mem_req_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_req_dropped: got %b expected 0", bus.mem_req_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h1234_5678;
        n_vec++; if (bus.mem_rsp_ready !== 1'b0) begin n_err++; $display("FAIL mid_rsp_ready: got %b expected 0", bus.mem_rsp_ready); end
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        run_txn(32'h8000_0020, MOP_BU, 1'b0, 1'b1, 32'h0, 32'h0000_00F0, 1'b0, 0, 0, 0, 32'h0000_00F0, 1'b1);
    endtask

    // TIMEOUT=8 instance: request either never accepted, or accepted with no response.
    task automatic test_timeout(input logic req_ok);
        int n, reqc;
        logic seen;
        tbus.in_valid = 1'b1; tbus.in_addr = 32'h8000_0040; tbus.in_memop = MOP_W;
        tbus.in_wen = 1'b0; tbus.in_ren = 1'b1; tbus.in_wdata = 32'h0;
        @(posedge clk); #1;
        tbus.in_valid = 1'b0;
        n = 1; reqc = 0; seen = 1'b0;
        repeat (30) begin
            if (!seen) begin
                if (tbus.out_valid) seen = 1'b1;
                else begin
                    if (tbus.mem_req_valid) reqc++;
                    tbus.mem_req_ready = req_ok && (n == 1);
                    n++;
                    @(posedge clk); #1;
                    tbus.mem_req_ready = 1'b0;
                end
            end
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL to_seen: got %b expected 1 (wait budget expired)", seen); end
        n_vec++; if (n != 9) begin n_err++; $display("FAIL to_latency: got %0d expected 9", n); end
        n_vec++; if (reqc != (req_ok ? 1 : 8)) begin n_err++; $display("FAIL to_req_cycles: got %0d expected %0d", reqc, req_ok ? 1 : 8); end
        n_vec++; if (tbus.out_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b expected 1", tbus.out_err); end
        n_vec++; if (tbus.out_rdata !== 32'h0) begin n_err++; $display("FAIL to_rdata: got %h expected 0", tbus.out_rdata); end
        tbus.out_ready = 1'b1;
        @(posedge clk); #1;
        tbus.out_ready = 1'b0;
        // late response in IDLE is ignored
        tbus.mem_rsp_valid = 1'b1; tbus.mem_rsp_rdata = 32'hFFFF_FFFF; tbus.mem_rsp_err = 1'b1;
        n_vec++; if (tbus.mem_rsp_ready !== 1'b0) begin n_err++; $display("FAIL to_late_rsp_ready: got %b expected 0", tbus.mem_rsp_ready); end
        @(posedge clk); #1;
        tbus.mem_rsp_valid = 1'b0; tbus.mem_rsp_err = 1'b0;
        n_vec++; if (tbus.out_valid !== 1'b0) begin n_err++; $display("FAIL to_late_out_valid: got %b expected 0", tbus.out_valid); end
        // following request is served normally
        tbus.in_valid = 1'b1; tbus.in_addr = 32'h8000_0044;
        @(posedge clk); #1;
        tbus.in_valid = 1'b0; tbus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        tbus.mem_req_ready = 1'b0; tbus.mem_rsp_valid = 1'b1; tbus.mem_rsp_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        tbus.mem_rsp_valid = 1'b0;
        n_vec++; if (tbus.out_valid !== 1'b1) begin n_err++; $display("FAIL to_next_valid: got %b expected 1", tbus.out_valid); end
        n_vec++; if (tbus.out_rdata !== 32'h1357_9BDF) begin n_err++; $display("FAIL to_next_rdata: got %h expected 13579bdf", tbus.out_rdata); end
        n_vec++; if (tbus.out_err !== 1'b0) begin n_err++; $display("FAIL to_next_err: got %b expected 0", tbus.out_err); end
        tbus.out_ready = 1'b1;
        @(posedge clk); #1;
        tbus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_memop = '0; bus.in_wen = 1'b0; bus.in_ren = 1'b0;
        bus.in_wdata = '0; bus.out_ready = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0; bus.mem_rsp_err = 1'b0;
        tbus.in_valid = 1'b0; tbus.in_addr = '0; tbus.in_memop = '0; tbus.in_wen = 1'b0; tbus.in_ren = 1'b0;
        tbus.in_wdata = '0; tbus.out_ready = 1'b0; tbus.mem_req_ready = 1'b0; tbus.mem_rsp_valid = 1'b0;
        tbus.mem_rsp_rdata = '0; tbus.mem_rsp_err = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid();
        test_timeout(1'b0);
        test_timeout(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
